card_dealer: RTL
================

# card_dealer

Card-dealer responder on the player command interface. `poker_player` drives `cr_cmdvld`/`cr_cmd`, and `card_dealer` executes each command against a 52-card deck, then returns `cr_ack` with a 6-bit card or status word. It sits beside `poker_player` under the table top level and shares its clock, reset and `tbl_game_start`.

## Interface
Parameters:
- None. Deck size is fixed at 52, card width at 6.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tbl_game_start` in 1: table game-start level; its rising edge refills the deck.
- `cr_cmdvld` in 1: command valid from the player; held until `cr_ack` is seen.
- `cr_cmd` in 3: command code. 000 NOP, 001 DRAW, 010 NEWDECK, 011 COUNT, 1xx illegal.
- `cr_ack` out 1: one-cycle acknowledge pulse.
- `cr_card` out 6: response data, `{suit[1:0], rank[3:0]}` with rank 1..13 (A=1, K=13), or the card count for COUNT.
- `cr_err` out 1: error flag for the current ack (illegal command, or DRAW on an empty deck).
- `cards_left` out 6: number of undealt cards, 0..52.

## Operation
- **Deck.** 52-bit dealt mask. Index i maps to suit = i/13 and rank = i%13+1. Keep suit/rank counters alongside the pointer; no divider.
- **States.** IDLE, EXEC, PROBE, ACK, WAITLOW.
- **IDLE.** `cr_cmdvld`=1 accepts the command: latch `cr_cmd`, go to EXEC.
- **EXEC.**
  - NOP: go to ACK.
  - NEWDECK: clear the mask, `cards_left`=52, next pointer=0; go to ACK with `cr_card`=0.
  - COUNT: go to ACK with `cr_card`=`cards_left`.
  - Illegal: go to ACK with `cr_err`=1; deck unchanged.
  - DRAW with `cards_left`=0: go to ACK with `cr_err`=1 and `cr_card`=0.
  - Other DRAW: load the probe pointer from the start index and go to PROBE.
- **PROBE.**
  - Pointer undealt: set its mask bit, decrement `cards_left`, latch the card, store pointer+1 (mod 52) as the next pointer, go to ACK.
  - Pointer dealt: pointer+1; 51 wraps to 0.
- **ACK.** `cr_ack`=1 for exactly one cycle. `cr_err`=0 unless set by an error case above.
  - If `cr_cmdvld`=0 at the edge, go to IDLE; otherwise go to WAITLOW.
- **WAITLOW.** Wait for `cr_cmdvld`=0, then go to IDLE. A held `cr_cmdvld` is never accepted twice.
- **Response hold.** `cr_card` and `cr_err` hold their values until the next ack.
- **Game start.** Registered rising-edge detect of `tbl_game_start` sets a pending flag.
  - The refill (same effect as NEWDECK, no ack) executes only in IDLE.
  - If a command is accepted on the same edge, the refill applies first and the command executes on the full deck.
  - A rising edge mid-command is deferred and never aborts a command or suppresses its ack.

## Timing
- **Reset values.** `cr_ack`=0, `cr_card`=0, `cr_err`=0, `cards_left`=52. State IDLE, mask clear, next pointer 0, LFSR 6'b000001, pending flag 0.
- **Command latency.** Command sampled at edge k:
  - NOP, NEWDECK, COUNT, illegal, and DRAW on an empty deck: `cr_ack` is high from edge k+2 to k+3.
  - Other DRAW: `cr_ack` is high from edge k+2+p, where p is the number of dealt cards skipped (0..51).
- **Throughput.** The earliest next accept is the edge after the ack cycle with `cr_cmdvld` low, then a new assertion.
- **Deck counter.** `cards_left` updates on the same edge the ack rises.

## Configuration
- `DEALER_SHUFFLE_EN` defined:
  - A 6-bit LFSR (x^6+x^5+1, seed 000001) advances every cycle.
  - DRAW start index is v if v<52, otherwise v−52, where v is the LFSR value sampled in EXEC.
- `DEALER_SHUFFLE_EN` undefined:
  - No LFSR. DRAW starts at the stored next pointer, so a fresh deck deals indices 0,1,2,…,51 in order with p=0.

## Test plan
1. **Reset.** Assert `rst_n`=0 mid-run → all outputs 0, `cards_left`=52, and no ack for 10 cycles after release.
2. **Sequential draws** (shuffle off). DRAW ×14 → cards 6'b00_0001, 6'b00_0010, …, and the 14th is 6'b01_0001. Each ack comes 2 cycles after accept; `cards_left` reaches 38.
3. **Empty deck.** 52 DRAWs, then a 53rd → `cr_err`=1, `cr_card`=0, `cards_left`=0, ack latency 2.
4. **COUNT and NEWDECK.** COUNT after 5 draws → `cr_card`=47. Then NEWDECK → `cards_left`=52, and the next DRAW returns 6'b00_0001.
5. **Illegal command with held valid.** `cr_cmd`=3'b101 with `cr_cmdvld` held 6 cycles → exactly one ack with `cr_err`=1; deck unchanged.
6. **Shuffle and deferred refill** (shuffle on).
   - 52 DRAWs return 52 distinct cards, each with latency ≤53.
   - A `tbl_game_start` rise during PROBE → that ack is still delivered, then `cards_left`=52 once the block is back in IDLE.

Source files
------------

// File: rtl/card_dealer.sv
// card_dealer: executes player DRAW/NEWDECK/COUNT/NOP commands against a 52-card deck and
// acknowledges each with a one-cycle pulse. Define DEALER_SHUFFLE_EN for LFSR-chosen draw start.
module card_dealer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tbl_game_start,
    input  logic       cr_cmdvld,
    input  logic [2:0] cr_cmd,
    output logic       cr_ack,
    output logic [5:0] cr_card,
    output logic       cr_err,
    output logic [5:0] cards_left
);
    localparam logic [2:0] CMD_NOP     = 3'b000;
    localparam logic [2:0] CMD_DRAW    = 3'b001;
    localparam logic [2:0] CMD_NEWDECK = 3'b010;
    localparam logic [2:0] CMD_COUNT   = 3'b011;
    localparam logic [5:0] DECK_SIZE   = 6'd52;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_PROBE, S_ACK, S_WAITLOW} state_t;
    state_t r_state, w_state_next;

    logic [2:0]  r_cmd;
    logic [51:0] r_mask;
    logic [5:0]  r_left, r_next_ptr, r_ptr;
    logic [1:0]  r_next_suit, r_suit;
    logic [3:0]  r_next_rank, r_rank;
    logic        r_hit, r_ack, r_err, r_gs_d, r_pend;
    logic [5:0]  r_card;

    logic        w_gs_rise, w_accept, w_refill, w_ptr_free, w_deal, w_commit, w_draw_ok;
    logic [5:0]  w_start, w_inc_ptr;
    logic [1:0]  w_start_suit, w_inc_suit;
    logic [3:0]  w_start_rank, w_inc_rank;

    assign w_gs_rise  = tbl_game_start & ~r_gs_d;
    assign w_accept   = (r_state == S_IDLE) && cr_cmdvld;
    assign w_refill   = (r_state == S_IDLE) && r_pend;
    assign w_ptr_free = ~r_mask[r_ptr];
    assign w_deal     = (r_state == S_PROBE) && w_ptr_free;
    // A DRAW hit is committed leaving PROBE; every other command commits leaving ACK.
    assign w_commit   = (r_state == S_ACK) && !r_hit;
    assign w_draw_ok  = (r_cmd == CMD_DRAW) && (r_left != 6'd0);

`ifdef DEALER_SHUFFLE_EN
    logic [5:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lfsr <= 6'b000001;
        else        r_lfsr <= {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};
    end

    // Rank from the low nibble: offsets are 1 - 13*suit taken mod 16.
    always_comb begin
        w_start = (r_lfsr < DECK_SIZE) ? r_lfsr : r_lfsr - DECK_SIZE;
        if (w_start < 6'd13) begin
            w_start_suit = 2'd0;
            w_start_rank = w_start[3:0] + 4'd1;
        end else if (w_start < 6'd26) begin
            w_start_suit = 2'd1;
            w_start_rank = w_start[3:0] + 4'd4;
        end else if (w_start < 6'd39) begin
            w_start_suit = 2'd2;
            w_start_rank = w_start[3:0] + 4'd7;
        end else begin
            w_start_suit = 2'd3;
            w_start_rank = w_start[3:0] + 4'd10;
        end
    end
`else
    assign w_start      = r_next_ptr;
    assign w_start_suit = r_next_suit;
    assign w_start_rank = r_next_rank;
`endif

    always_comb begin
        w_inc_ptr = (r_ptr == 6'd51) ? 6'd0 : r_ptr + 6'd1;
        if (r_rank == 4'd13) begin
            w_inc_rank = 4'd1;
            w_inc_suit = r_suit + 2'd1;
        end else begin
            w_inc_rank = r_rank + 4'd1;
            w_inc_suit = r_suit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (cr_cmdvld) w_state_next = S_EXEC;
            S_EXEC:    w_state_next = w_draw_ok ? S_PROBE : S_ACK;
            S_PROBE:   if (w_ptr_free) w_state_next = S_ACK;
            S_ACK:     w_state_next = cr_cmdvld ? S_WAITLOW : S_IDLE;
            S_WAITLOW: if (!cr_cmdvld) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd       <= CMD_NOP;
            r_mask      <= '0;
            r_left      <= DECK_SIZE;
            r_next_ptr  <= 6'd0;
            r_next_suit <= 2'd0;
            r_next_rank <= 4'd1;
            r_ptr       <= 6'd0;
            r_suit      <= 2'd0;
            r_rank      <= 4'd1;
            r_hit       <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_card      <= 6'd0;
            r_gs_d      <= 1'b0;
            r_pend      <= 1'b0;
        end else begin
            r_gs_d <= tbl_game_start;
            r_ack  <= w_deal || w_commit;

            if (w_gs_rise)     r_pend <= 1'b1;
            else if (w_refill) r_pend <= 1'b0;

            if (w_refill) begin
                r_mask      <= '0;
                r_left      <= DECK_SIZE;
                r_next_ptr  <= 6'd0;
                r_next_suit <= 2'd0;
                r_next_rank <= 4'd1;
            end

            if (w_accept) r_cmd <= cr_cmd;

            if (r_state == S_EXEC) begin
                r_ptr  <= w_start;
                r_suit <= w_start_suit;
                r_rank <= w_start_rank;
            end

            if (r_state == S_PROBE) begin
                if (w_ptr_free) begin
                    r_mask[r_ptr] <= 1'b1;
                    r_left        <= r_left - 6'd1;
                    r_card        <= {r_suit, r_rank};
                    r_err         <= 1'b0;
                    r_hit         <= 1'b1;
                    r_next_ptr    <= w_inc_ptr;
                    r_next_suit   <= w_inc_suit;
                    r_next_rank   <= w_inc_rank;
                end else begin
                    r_ptr  <= w_inc_ptr;
                    r_suit <= w_inc_suit;
                    r_rank <= w_inc_rank;
                end
            end

            if (r_state == S_ACK) r_hit <= 1'b0;

            if (w_commit) begin
                r_err <= 1'b0;
                case (r_cmd)
                    CMD_NOP: ;
                    CMD_NEWDECK: begin
                        r_mask      <= '0;
                        r_left      <= DECK_SIZE;
                        r_next_ptr  <= 6'd0;
                        r_next_suit <= 2'd0;
                        r_next_rank <= 4'd1;
                        r_card      <= 6'd0;
                    end
                    CMD_COUNT: r_card <= r_left;
                    // Only an empty-deck DRAW reaches ACK without a hit.
                    CMD_DRAW: begin
                        r_err  <= 1'b1;
                        r_card <= 6'd0;
                    end
                    default: r_err <= 1'b1;
                endcase
            end
        end
    end

    assign cr_ack     = r_ack;
    assign cr_card    = r_card;
    assign cr_err     = r_err;
    assign cards_left = r_left;

endmodule
